race_state_controller: RTL

Top-level game sequencer that produces the 3-bit game state consumed by the keyboard operation encoder and both physics engines.
It runs the flow IDLE -> INIT -> COUNTDOWN -> RACING -> FINISH, with PAUSED reachable from RACING.
It counts laps for both players from their world positions, keeps the race clock and declares the winner.
It sits beside the physics engines in Top and replaces the constant RACING state currently tied to their state inputs.

---
 rtl/race_state_controller_pkg.sv | 26 ++
 rtl/race_state_controller_lap_tracker.sv | 56 +++++
 rtl/race_state_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/race_state_controller_pkg.sv
// Shared game-state codes, winner codes and widths for the race sequencer.
package race_state_controller_pkg;

    localparam int unsigned LAP_W   = 3;
    localparam int unsigned POS_W   = 10;
    localparam int unsigned SEC_W   = 10;
    localparam int unsigned SEC_MAX = 999;

    // RACING = 4 is hard-wired into the physics engines and the keyboard encoder.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_COUNTDOWN = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_RACING    = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_TIE  = 2'd3
    } winner_t;

endpackage

// File: rtl/race_state_controller_lap_tracker.sv
// Per-player lap counter: a checkpoint visit arms the player, the next finish-box visit counts a lap.
module lap_tracker
    import race_state_controller_pkg::*;
#(
    parameter int unsigned LAPS   = 3,
    parameter int unsigned FIN_X0 = 5,
    parameter int unsigned FIN_X1 = 35,
    parameter int unsigned FIN_Y0 = 120,
    parameter int unsigned FIN_Y1 = 130,
    parameter int unsigned CP_X0  = 280,
    parameter int unsigned CP_X1  = 310,
    parameter int unsigned CP_Y0  = 110,
    parameter int unsigned CP_Y1  = 130
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [POS_W-1:0] x,
    input  logic [POS_W-1:0] y,
    output logic [LAP_W-1:0] lap,
    output logic             done_c
);

    logic in_fin_c;
    logic in_cp_c;
    logic armed;
    logic count_c;

    // Inclusive unsigned box tests on the live position.
    assign in_fin_c = (x >= POS_W'(FIN_X0)) && (x <= POS_W'(FIN_X1)) &&
                      (y >= POS_W'(FIN_Y0)) && (y <= POS_W'(FIN_Y1));
    assign in_cp_c  = (x >= POS_W'(CP_X0)) && (x <= POS_W'(CP_X1)) &&
                      (y >= POS_W'(CP_Y0)) && (y <= POS_W'(CP_Y1));

    // A lap counts on this edge; done_c flags the edge on which the final lap lands.
    assign count_c = en && in_fin_c && armed && (lap < LAP_W'(LAPS));
    assign done_c  = count_c && (lap == LAP_W'(LAPS - 1));

    // Armed flag and lap counter; both hold whenever en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap   <= '0;
            armed <= 1'b0;
        end else if (clr) begin
            lap   <= '0;
            armed <= 1'b0;
        end else if (count_c) begin
            lap   <= lap + LAP_W'(1);
            armed <= 1'b0;
        end else if (en && in_cp_c) begin
            armed <= 1'b1;
        end
    end

endmodule

// File: rtl/race_state_controller.sv
// Game sequencer: IDLE -> INIT -> COUNTDOWN -> RACING (<-> PAUSED) -> FINISH, with laps, race clock and winner.
module race_state_controller
    import race_state_controller_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned COUNT_SECS = 3,
    parameter int unsigned LAPS       = 3,
    parameter int unsigned FIN_X0     = 5,
    parameter int unsigned FIN_X1     = 35,
    parameter int unsigned FIN_Y0     = 120,
    parameter int unsigned FIN_Y1     = 130,
    parameter int unsigned CP_X0      = 280,
    parameter int unsigned CP_X1      = 310,
    parameter int unsigned CP_Y0      = 110,
    parameter int unsigned CP_Y1      = 130
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_pulse,
    input  logic             pause_pulse,
    input  logic [POS_W-1:0] p1_x,
    input  logic [POS_W-1:0] p1_y,
    input  logic [POS_W-1:0] p2_x,
    input  logic [POS_W-1:0] p2_y,
    output logic [2:0]       state,
    output logic             init_pulse,
    output logic [1:0]       countdown,
    output logic [LAP_W-1:0] p1_lap,
    output logic [LAP_W-1:0] p2_lap,
    output logic [1:0]       winner,
    output logic [SEC_W-1:0] race_sec
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t            st;
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_next_c;
    logic              tick_c;
    logic              race_en_c;
    logic              clr_c;
    logic              p1_done_c;
    logic              p2_done_c;

    assign state       = st;
    assign tick_c      = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign tick_next_c = tick_c ? '0 : tick_cnt + TICK_W'(1);
    assign race_en_c   = (st == ST_RACING);
    // Laps are wiped when a race is set up and when FINISH returns to IDLE.
    assign clr_c       = (st == ST_INIT) || ((st == ST_FINISH) && start_pulse);

    lap_tracker #(
        .LAPS(LAPS), .FIN_X0(FIN_X0), .FIN_X1(FIN_X1), .FIN_Y0(FIN_Y0), .FIN_Y1(FIN_Y1),
        .CP_X0(CP_X0), .CP_X1(CP_X1), .CP_Y0(CP_Y0), .CP_Y1(CP_Y1)
    ) u_p1 (
        .clk(clk), .rst(rst), .clr(clr_c), .en(race_en_c),
        .x(p1_x), .y(p1_y), .lap(p1_lap), .done_c(p1_done_c)
    );

    lap_tracker #(
        .LAPS(LAPS), .FIN_X0(FIN_X0), .FIN_X1(FIN_X1), .FIN_Y0(FIN_Y0), .FIN_Y1(FIN_Y1),
        .CP_X0(CP_X0), .CP_X1(CP_X1), .CP_Y0(CP_Y0), .CP_Y1(CP_Y1)
    ) u_p2 (
        .clk(clk), .rst(rst), .clr(clr_c), .en(race_en_c),
        .x(p2_x), .y(p2_y), .lap(p2_lap), .done_c(p2_done_c)
    );

    // Sequencer with registered countdown, race clock, winner and init pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= ST_IDLE;
            tick_cnt   <= '0;
            init_pulse <= 1'b0;
            countdown  <= '0;
            winner     <= WIN_NONE;
            race_sec   <= '0;
        end else begin
            init_pulse <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (start_pulse) begin
                        st         <= ST_INIT;
                        init_pulse <= 1'b1;
                    end
                end
                ST_INIT: begin
                    countdown <= 2'(COUNT_SECS);
                    tick_cnt  <= '0;
                    winner    <= WIN_NONE;
                    race_sec  <= '0;
                    st        <= ST_COUNTDOWN;
                end
                ST_COUNTDOWN: begin
                    tick_cnt <= tick_next_c;
                    if (tick_c) begin
                        if (countdown == 2'd1) begin
                            countdown <= '0;
                            st        <= ST_RACING;
                        end else begin
                            countdown <= countdown - 2'd1;
                        end
                    end
                end
                ST_RACING: begin
                    tick_cnt <= tick_next_c;
                    if (tick_c && (race_sec != SEC_W'(SEC_MAX))) begin
                        race_sec <= race_sec + SEC_W'(1);
                    end
                    // The final lap wins over a simultaneous pause request.
                    if (p1_done_c && p2_done_c) begin
                        winner <= WIN_TIE;
                        st     <= ST_FINISH;
                    end else if (p1_done_c) begin
                        winner <= WIN_P1;
                        st     <= ST_FINISH;
                    end else if (p2_done_c) begin
                        winner <= WIN_P2;
                        st     <= ST_FINISH;
                    end else if (pause_pulse) begin
                        st <= ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (pause_pulse) begin
                        st <= ST_RACING;
                    end
                end
                ST_FINISH: begin
                    if (start_pulse) begin
                        st        <= ST_IDLE;
                        tick_cnt  <= '0;
                        countdown <= '0;
                        winner    <= WIN_NONE;
                        race_sec  <= '0;
                    end
                end
                default: begin
                    st        <= ST_IDLE;
                    tick_cnt  <= '0;
                    countdown <= '0;
                    winner    <= WIN_NONE;
                    race_sec  <= '0;
                end
            endcase
        end
    end

endmodule
